// File: rtl/control_sequencer.sv
// Microcoded T-state sequencer for the 8-bit bus CPU: steps fetch/execute
// and decodes the IR into per-cycle bus read/write enables.
module control_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] instruction,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       pc_out,
  output logic       ram_out,
  output logic       ir_out,
  output logic       a_out,
  output logic       alu_out,
  output logic       mar_in,
  output logic       ram_in,
  output logic       ir_in,
  output logic       a_in,
  output logic       b_in,
  output logic       out_in,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       alu_sub,
  output logic       flags_in,
  output logic [2:0] step,
  output logic       halted
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd7;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0] state;
  logic [2:0] state_next;
  logic [3:0] opcode;
  logic       unused_operand;

  assign opcode = instruction[7:4];
  // The operand nibble reaches the bus through the IR itself, not through here.
  assign unused_operand = ^instruction[3:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (run) state_next = S_T0;
      S_T0:   if (run) state_next = S_T1;
      S_T1:
        if (run) begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
            OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: state_next = S_T2;
            default:                              state_next = S_T0;
          endcase
        end
      S_T2:
        if (run) begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: state_next = S_T3;
            OP_HLT:                         state_next = S_HALT;
            default:                        state_next = S_T0;
          endcase
        end
      S_T3:
        if (run) begin
          if (opcode == OP_ADD || opcode == OP_SUB) state_next = S_T4;
          else                                      state_next = S_T0;
        end
      S_T4:   if (run) state_next = S_T0;
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_out   = 1'b0;
    ram_out  = 1'b0;
    ir_out   = 1'b0;
    a_out    = 1'b0;
    alu_out  = 1'b0;
    mar_in   = 1'b0;
    ram_in   = 1'b0;
    ir_in    = 1'b0;
    a_in     = 1'b0;
    b_in     = 1'b0;
    out_in   = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    alu_sub  = 1'b0;
    flags_in = 1'b0;
    // Gating on run keeps a frozen T-state from issuing a partial micro-op.
    if (run) begin
      case (state)
        S_T0: begin
          pc_out = 1'b1;
          mar_in = 1'b1;
        end
        S_T1: begin
          ram_out = 1'b1;
          ir_in   = 1'b1;
          pc_inc  = 1'b1;
        end
        S_T2:
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out = 1'b1;
              mar_in = 1'b1;
            end
            OP_LDI: begin
              ir_out = 1'b1;
              a_in   = 1'b1;
            end
            OP_JMP: begin
              ir_out  = 1'b1;
              pc_load = 1'b1;
            end
            OP_JC: begin
              ir_out  = carry_flag;
              pc_load = carry_flag;
            end
            OP_JZ: begin
              ir_out  = zero_flag;
              pc_load = zero_flag;
            end
            OP_OUT: begin
              a_out  = 1'b1;
              out_in = 1'b1;
            end
            default: ;
          endcase
        S_T3:
          case (opcode)
            OP_LDA: begin
              ram_out = 1'b1;
              a_in    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_out = 1'b1;
              b_in    = 1'b1;
            end
            OP_STA: begin
              a_out  = 1'b1;
              ram_in = 1'b1;
            end
            default: ;
          endcase
        S_T4:
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out  = 1'b1;
            a_in     = 1'b1;
            flags_in = 1'b1;
            alu_sub  = (opcode == OP_SUB);
          end
        default: ;
      endcase
    end
  end

  assign step   = state;
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes the hand-derived
// per-cycle output vector, a negedge monitor pops and compares.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [7:0] instruction;
  logic       carry_flag;
  logic       zero_flag;
  logic pc_out, ram_out, ir_out, a_out, alu_out;
  logic mar_in, ram_in, ir_in, a_in, b_in, out_in;
  logic pc_inc, pc_load, alu_sub, flags_in;
  logic [2:0] step;
  logic       halted;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [18:0] exp_q[$];

  localparam logic [14:0] PO = 15'h4000, RO = 15'h2000, IRO = 15'h1000;
  localparam logic [14:0] AO = 15'h0800, ALUO = 15'h0400, MI = 15'h0200;
  localparam logic [14:0] RI = 15'h0100, II = 15'h0080, AI = 15'h0040;
  localparam logic [14:0] BI = 15'h0020, OI = 15'h0010, PI = 15'h0008;
  localparam logic [14:0] PL = 15'h0004, SU = 15'h0002, FI = 15'h0001;
  localparam logic [14:0] NONE = 15'h0000;

  control_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .instruction(instruction),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .pc_out(pc_out), .ram_out(ram_out), .ir_out(ir_out), .a_out(a_out),
    .alu_out(alu_out), .mar_in(mar_in), .ram_in(ram_in), .ir_in(ir_in),
    .a_in(a_in), .b_in(b_in), .out_in(out_in), .pc_inc(pc_inc),
    .pc_load(pc_load), .alu_sub(alu_sub), .flags_in(flags_in),
    .step(step), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [18:0] got;
  assign got = {step, halted, pc_out, ram_out, ir_out, a_out, alu_out,
                mar_in, ram_in, ir_in, a_in, b_in, out_in,
                pc_inc, pc_load, alu_sub, flags_in};

  function automatic logic [18:0] e(input logic [2:0] s, input logic h,
                                    input logic [14:0] c);
    return {s, h, c};
  endfunction

  // One clock of stimulus: drive inputs just after the edge, queue the expected outputs.
  task automatic cyc(input logic r, input logic [7:0] ins, input logic c,
                     input logic z, input logic [2:0] s, input logic [14:0] ctl);
    run = r; instruction = ins; carry_flag = c; zero_flag = z;
    exp_q.push_back(e(s, (s == 3'd7), ctl));
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    logic [18:0] want;
    total++;
    if ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) begin
      bad++;
      $display("FAIL bus_writers t=%0t got=%b required=at most one", $time,
               {pc_out, ram_out, ir_out, a_out, alu_out});
    end
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL outputs t=%0t got step=%0d halt=%b ctl=%b required step=%0d halt=%b ctl=%b",
                 $time, got[18:16], got[15], got[14:0], want[18:16], want[15], want[14:0]);
      end
    end
  end

  initial begin
    rst = 1'b0; run = 1'b0; instruction = 8'h00; carry_flag = 1'b0; zero_flag = 1'b0;
    @(posedge clk); #1;
    cyc(1'b1, 8'h2C, 1'b1, 1'b1, 3'd0, NONE);   // run high while held in reset
    rst = 1'b1;
    cyc(1'b0, 8'h1E, 1'b0, 1'b0, 3'd0, NONE);
    cyc(1'b1, 8'h1E, 1'b0, 1'b0, 3'd0, NONE);
    // LDA 0x1E
    cyc(1'b1, 8'h1E, 1'b0, 1'b0, 3'd1, PO | MI);
    cyc(1'b1, 8'h1E, 1'b0, 1'b0, 3'd2, RO | II | PI);
    cyc(1'b1, 8'h1E, 1'b0, 1'b0, 3'd3, IRO | MI);
    cyc(1'b1, 8'h1E, 1'b0, 1'b0, 3'd4, RO | AI);
    // SUB 0x3F
    cyc(1'b1, 8'h3F, 1'b0, 1'b0, 3'd1, PO | MI);
    cyc(1'b1, 8'h3F, 1'b0, 1'b0, 3'd2, RO | II | PI);
    cyc(1'b1, 8'h3F, 1'b0, 1'b0, 3'd3, IRO | MI);
    cyc(1'b1, 8'h3F, 1'b0, 1'b0, 3'd4, RO | BI);
    cyc(1'b1, 8'h3F, 1'b0, 1'b0, 3'd5, ALUO | AI | FI | SU);
    // ADD 0x2C
    cyc(1'b1, 8'h2C, 1'b0, 1'b0, 3'd1, PO | MI);
    cyc(1'b1, 8'h2C, 1'b0, 1'b0, 3'd2, RO | II | PI);
    cyc(1'b1, 8'h2C, 1'b0, 1'b0, 3'd3, IRO | MI);
    cyc(1'b1, 8'h2C, 1'b0, 1'b0, 3'd4, RO | BI);
    cyc(1'b1, 8'h2C, 1'b0, 1'b0, 3'd5, ALUO | AI | FI);
    // JC 0x7A not taken (zero set, carry clear), then taken
    cyc(1'b1, 8'h7A, 1'b0, 1'b1, 3'd1, PO | MI);
    cyc(1'b1, 8'h7A, 1'b0, 1'b1, 3'd2, RO | II | PI);
    cyc(1'b1, 8'h7A, 1'b0, 1'b1, 3'd3, NONE);
    cyc(1'b1, 8'h7A, 1'b1, 1'b0, 3'd1, PO | MI);
    cyc(1'b1, 8'h7A, 1'b1, 1'b0, 3'd2, RO | II | PI);
    cyc(1'b1, 8'h7A, 1'b1, 1'b0, 3'd3, IRO | PL);
    // JZ 0x85 not taken (carry set, zero clear), then taken
    cyc(1'b1, 8'h85, 1'b1, 1'b0, 3'd1, PO | MI);
    cyc(1'b1, 8'h85, 1'b1, 1'b0, 3'd2, RO | II | PI);
    cyc(1'b1, 8'h85, 1'b1, 1'b0, 3'd3, NONE);
    cyc(1'b1, 8'h85, 1'b0, 1'b1, 3'd1, PO | MI);
    cyc(1'b1, 8'h85, 1'b0, 1'b1, 3'd2, RO | II | PI);
    cyc(1'b1, 8'h85, 1'b0, 1'b1, 3'd3, IRO | PL);
    // LDI 0x57, JMP 0x63, OUT 0xE0
    cyc(1'b1, 8'h57, 1'b0, 1'b0, 3'd1, PO | MI);
    cyc(1'b1, 8'h57, 1'b0, 1'b0, 3'd2, RO | II | PI);
    cyc(1'b1, 8'h57, 1'b0, 1'b0, 3'd3, IRO | AI);
    cyc(1'b1, 8'h63, 1'b0, 1'b0, 3'd1, PO | MI);
    cyc(1'b1, 8'h63, 1'b0, 1'b0, 3'd2, RO | II | PI);
    cyc(1'b1, 8'h63, 1'b0, 1'b0, 3'd3, IRO | PL);
    cyc(1'b1, 8'hE0, 1'b0, 1'b0, 3'd1, PO | MI);
    cyc(1'b1, 8'hE0, 1'b0, 1'b0, 3'd2, RO | II | PI);
    cyc(1'b1, 8'hE0, 1'b0, 1'b0, 3'd3, AO | OI);
    // NOP 0x00 and undefined 0xB0: two cycles each
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 3'd1, PO | MI);
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 3'd2, RO | II | PI);
    cyc(1'b1, 8'hB0, 1'b0, 1'b0, 3'd1, PO | MI);
    cyc(1'b1, 8'hB0, 1'b0, 1'b0, 3'd2, RO | II | PI);
    // STA 0x4F with run dropped for three cycles at T2
    cyc(1'b1, 8'h4F, 1'b0, 1'b0, 3'd1, PO | MI);
    cyc(1'b1, 8'h4F, 1'b0, 1'b0, 3'd2, RO | II | PI);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h4F, 1'b1, 1'b1, 3'd3, NONE);
    cyc(1'b1, 8'h4F, 1'b0, 1'b0, 3'd3, IRO | MI);
    cyc(1'b1, 8'h4F, 1'b0, 1'b0, 3'd4, AO | RI);
    // ADD 0x2C interrupted by reset in T3
    cyc(1'b1, 8'h2C, 1'b0, 1'b0, 3'd1, PO | MI);
    cyc(1'b1, 8'h2C, 1'b0, 1'b0, 3'd2, RO | II | PI);
    cyc(1'b1, 8'h2C, 1'b0, 1'b0, 3'd3, IRO | MI);
    exp_q.push_back(e(3'd0, 1'b0, NONE));
    #1;
    total++;
    if (got !== e(3'd4, 1'b0, RO | BI)) begin
      bad++;
      $display("FAIL pre_reset_t3 got=%b required=%b", got, e(3'd4, 1'b0, RO | BI));
    end
    rst = 1'b0;
    #1;
    total++;
    if (got !== 19'd0) begin
      bad++;
      $display("FAIL async_reset got=%b required=%b", got, 19'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(1'b1, 8'h2C, 1'b0, 1'b0, 3'd0, NONE);
    // HLT 0xF0, then run toggling in HALT
    cyc(1'b1, 8'hF0, 1'b0, 1'b0, 3'd1, PO | MI);
    cyc(1'b1, 8'hF0, 1'b0, 1'b0, 3'd2, RO | II | PI);
    cyc(1'b1, 8'hF0, 1'b0, 1'b0, 3'd3, NONE);
    cyc(1'b1, 8'hF0, 1'b0, 1'b0, 3'd7, NONE);
    cyc(1'b0, 8'h1E, 1'b1, 1'b1, 3'd7, NONE);
    cyc(1'b1, 8'h2C, 1'b1, 1'b1, 3'd7, NONE);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 3'd7, NONE);
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 3'd7, NONE);
    @(negedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
